// File: rtl/csi_framer.sv
// CSI framer: buffers one equalizer CSI frame, validates its length, prepends a header word
// and streams the framed packet to the DMA. Define CSI_FRAMER_TIMESTAMP_EN to add a timestamp word.
module csi_framer #(
  parameter int          FRAME_LEN = 64,
  parameter logic [15:0] MAGIC     = 16'hC510,
  parameter int          DROP_W    = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              csi_axis_tvalid,
  input  logic              csi_axis_tlast,
  input  logic [31:0]       csi_axis_tdata,
  output logic              csi_axis_tready,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic [31:0]       m_axis_tdata,
  input  logic              m_axis_tready,
  output logic [DROP_W-1:0] frames_dropped_out,
  output logic              busy_out
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ZERO_IDX = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_DISCARD = 3'd1,
    S_HDR     = 3'd2,
`ifdef CSI_FRAMER_TIMESTAMP_EN
    S_TS      = 3'd3,
`endif
    S_DATA    = 3'd4
  } state_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [15:0]         seq_q, seq_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [31:0]         hdr_q, hdr_d;
  logic                mvalid_q, mvalid_d;
  logic                mlast_q, mlast_d;
  logic                tready_q, tready_d;
  logic                busy_q, busy_d;
  logic                in_fire, out_fire;
  logic                wr_en, rd_en;
  logic [CNT_W-1:0]    rd_addr;
  logic [31:0]         mem [FRAME_LEN];
  logic [31:0]         ram_q;
`ifdef CSI_FRAMER_TIMESTAMP_EN
  logic [31:0]         ts_cnt_q;
  logic [31:0]         ts_cap_q, ts_cap_d;
`endif

  assign in_fire  = csi_axis_tvalid && tready_q;
  assign out_fire = mvalid_q && m_axis_tready;

  // Next-state logic; the RAM is read one beat ahead so data words follow the header back to back.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    hdr_d    = hdr_q;
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = ZERO_IDX;
`ifdef CSI_FRAMER_TIMESTAMP_EN
    ts_cap_d = ts_cap_q;
`endif
    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          wr_en = 1'b1;
`ifdef CSI_FRAMER_TIMESTAMP_EN
          if (count_q == ZERO_IDX) begin
            ts_cap_d = ts_cnt_q;
          end else begin
            ts_cap_d = ts_cap_q;
          end
`endif
          if (csi_axis_tlast) begin
            count_d = ZERO_IDX;
            if (count_q == LAST_IDX) begin
              state_d  = S_HDR;
              mvalid_d = 1'b1;
              mlast_d  = 1'b0;
              hdr_d    = {MAGIC, seq_q};
            end else begin
              drop_d = sat_inc(drop_q);
            end
          end else if (count_q == LAST_IDX) begin
            state_d = S_DISCARD;
            count_d = ZERO_IDX;
          end else begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          count_d = count_q;
        end
      end
      S_DISCARD: begin
        if (in_fire && csi_axis_tlast) begin
          drop_d  = sat_inc(drop_q);
          count_d = ZERO_IDX;
          state_d = S_FILL;
        end else begin
          state_d = S_DISCARD;
        end
      end
      S_HDR: begin
        rd_en = 1'b1;
        if (out_fire) begin
`ifdef CSI_FRAMER_TIMESTAMP_EN
          state_d = S_TS;
          hdr_d   = ts_cap_q;
`else
          state_d = S_DATA;
          idx_d   = ZERO_IDX;
          mlast_d = (LAST_IDX == ZERO_IDX);
`endif
        end else begin
          state_d = S_HDR;
        end
      end
`ifdef CSI_FRAMER_TIMESTAMP_EN
      S_TS: begin
        rd_en = 1'b1;
        if (out_fire) begin
          state_d = S_DATA;
          idx_d   = ZERO_IDX;
          mlast_d = (LAST_IDX == ZERO_IDX);
        end else begin
          state_d = S_TS;
        end
      end
`endif
      S_DATA: begin
        if (out_fire) begin
          if (idx_q == LAST_IDX) begin
            state_d  = S_FILL;
            mvalid_d = 1'b0;
            mlast_d  = 1'b0;
            hdr_d    = 32'h0000_0000;
            seq_d    = seq_q + 16'd1;
            count_d  = ZERO_IDX;
          end else begin
            rd_en   = 1'b1;
            rd_addr = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_d   = rd_addr;
            mlast_d = (rd_addr == LAST_IDX);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d  = S_FILL;
        mvalid_d = 1'b0;
        mlast_d  = 1'b0;
        count_d  = ZERO_IDX;
      end
    endcase
    tready_d = (state_d == S_FILL) || (state_d == S_DISCARD);
    busy_d   = !((state_d == S_FILL) && (count_d == ZERO_IDX));
  end

  // Control and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_FILL;
      count_q  <= ZERO_IDX;
      idx_q    <= ZERO_IDX;
      seq_q    <= 16'd0;
      drop_q   <= {DROP_W{1'b0}};
      hdr_q    <= 32'h0000_0000;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      tready_q <= 1'b1;
      busy_q   <= 1'b0;
`ifdef CSI_FRAMER_TIMESTAMP_EN
      ts_cnt_q <= 32'd0;
      ts_cap_q <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      hdr_q    <= hdr_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
`ifdef CSI_FRAMER_TIMESTAMP_EN
      ts_cnt_q <= ts_cnt_q + 32'd1;
      ts_cap_q <= ts_cap_d;
`endif
    end
  end

  // Frame buffer with registered read port; the read register holds still while the DMA stalls.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[count_q] <= csi_axis_tdata;
    end
    if (rd_en) begin
      ram_q <= mem[rd_addr];
    end
  end

  assign csi_axis_tready    = tready_q;
  assign m_axis_tvalid      = mvalid_q;
  assign m_axis_tlast       = mlast_q;
  assign m_axis_tdata       = (state_q == S_DATA) ? ram_q : hdr_q;
  assign frames_dropped_out = drop_q;
  assign busy_out           = busy_q;

endmodule

// File: tb/tb_csi_framer.sv
// Self-checking bench for csi_framer (default build): scoreboard of expected output beats.
module tb_csi_framer;

  localparam int FL = 64;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        csi_axis_tvalid;
  logic        csi_axis_tlast;
  logic [31:0] csi_axis_tdata;
  logic        csi_axis_tready;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tready;
  logic [15:0] frames_dropped_out;
  logic        busy_out;

  int          total = 0;
  int          bad = 0;
  int          out_beats = 0;
  bit          rand_mode = 1'b0;
  logic [32:0] sb[$];
  logic        prev_stall = 1'b0;
  logic        prev_fire_nl = 1'b0;
  logic [32:0] prev_word = 33'd0;
  logic [32:0] exp_word;
  int          s0;
  int          g;

  csi_framer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .csi_axis_tvalid(csi_axis_tvalid), .csi_axis_tlast(csi_axis_tlast),
    .csi_axis_tdata(csi_axis_tdata), .csi_axis_tready(csi_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready),
    .frames_dropped_out(frames_dropped_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] seq, input logic [31:0] base);
    sb.push_back({1'b0, 16'hC510, seq});
    for (int k = 0; k < FL; k++) begin
      sb.push_back({(k == FL - 1), 32'(base + 32'(k))});
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    int w;
    for (int k = 0; k < n; k++) begin
      csi_axis_tvalid = 1'b1;
      csi_axis_tdata  = 32'(base + 32'(k));
      csi_axis_tlast  = (k == n - 1);
      w = 0;
      while (!csi_axis_tready && w < 1000) begin
        @(negedge clk_in);
        w++;
      end
      if (w >= 1000) begin
        chk("in_timeout", 64'(w), 64'd0);
        break;
      end
      @(negedge clk_in);
    end
    csi_axis_tvalid = 1'b0;
    csi_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst_in          = 1'b1;
    csi_axis_tvalid = 1'b0;
    csi_axis_tlast  = 1'b0;
    csi_axis_tdata  = 32'd0;
    rand_mode       = 1'b0;
    repeat (2) @(negedge clk_in);
    sb.delete();
    rst_in = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge clk_in);
      w++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (5) @(negedge clk_in);
  endtask

  // Output monitor: handshakes are judged at the negedge before the edge that completes them.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_stall   = 1'b0;
        prev_fire_nl = 1'b0;
        m_axis_tready = 1'b1;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
          chk("stall_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_word));
        end
        if (prev_fire_nl && !rand_mode) begin
          chk("no_bubble", 64'(m_axis_tvalid), 64'd1);
        end
        m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_stall   = m_axis_tvalid && !m_axis_tready;
        prev_word    = {m_axis_tlast, m_axis_tdata};
        prev_fire_nl = m_axis_tvalid && m_axis_tready && !m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
          chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp_word = sb.pop_front();
            chk("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_word));
          end
          out_beats++;
        end
      end
    end
  end

  initial begin
    rst_in = 1'b1;
    csi_axis_tvalid = 1'b0;
    csi_axis_tlast  = 1'b0;
    csi_axis_tdata  = 32'd0;
    @(negedge clk_in);

    // Reset state
    do_reset();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_tready", 64'(csi_axis_tready), 64'd1);
    chk("rst_drops", 64'(frames_dropped_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);

    // Single valid frame, data = k
    push_frame(16'd0, 32'd0);
    send_frame(FL, 32'd0);
    if (!m_axis_tvalid) @(negedge clk_in);
    chk("latency", 64'(m_axis_tvalid), 64'd1);
    wait_drain();
    chk("t1_drops", 64'(frames_dropped_out), 64'd0);
    chk("t1_busy", 64'(busy_out), 64'd0);
    chk("t1_tvalid_idle", 64'(m_axis_tvalid), 64'd0);

    // Two back-to-back frames: seq 0 then 1, upstream held off while draining
    do_reset();
    push_frame(16'd0, 32'h1000_0000);
    push_frame(16'd1, 32'h2000_0000);
    send_frame(FL, 32'h1000_0000);
    chk("b2b_busy", 64'(busy_out), 64'd1);
    for (int i = 0; i < 60; i++) begin
      chk("b2b_tready_low", 64'(csi_axis_tready), 64'd0);
      @(negedge clk_in);
    end
    send_frame(FL, 32'h2000_0000);
    wait_drain();

    // Short frame dropped, then valid frame carries seq 0
    do_reset();
    send_frame(10, 32'h0000_0100);
    chk("short_drops", 64'(frames_dropped_out), 64'd1);
    chk("short_busy", 64'(busy_out), 64'd0);
    chk("short_no_out", 64'(m_axis_tvalid), 64'd0);
    push_frame(16'd0, 32'h0000_0200);
    send_frame(FL, 32'h0000_0200);
    wait_drain();
    chk("short_drops_after", 64'(frames_dropped_out), 64'd1);

    // Long frame fully consumed and dropped
    do_reset();
    send_frame(70, 32'h0000_0300);
    chk("long_drops", 64'(frames_dropped_out), 64'd1);
    chk("long_no_out", 64'(m_axis_tvalid), 64'd0);
    chk("long_tready", 64'(csi_axis_tready), 64'd1);
    push_frame(16'd0, 32'h0000_0400);
    send_frame(FL, 32'h0000_0400);
    wait_drain();

    // Random DMA backpressure
    do_reset();
    rand_mode = 1'b1;
    push_frame(16'd0, 32'd0);
    send_frame(FL, 32'd0);
    wait_drain();
    rand_mode = 1'b0;
    repeat (2) @(negedge clk_in);

    // Reset mid-drain
    do_reset();
    push_frame(16'd0, 32'h0000_0500);
    s0 = out_beats;
    send_frame(FL, 32'h0000_0500);
    g = 0;
    while ((out_beats - s0) < 30 && g < 500) begin
      @(negedge clk_in);
      g++;
    end
    chk("mid_beats_reached", 64'((out_beats - s0) >= 30), 64'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    sb.delete();
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("mid_rst_tready", 64'(csi_axis_tready), 64'd1);
    push_frame(16'd0, 32'h0000_0600);
    send_frame(FL, 32'h0000_0600);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csi_framer.md
Name: csi_framer

Overview:
- Sits directly downstream of the CSI extractor.
- Consumes the equalizer's CSI AXI-Stream: one frame of FRAME_LEN 32-bit {re,im} words per detected packet, with tlast on the final word.
- Buffers a complete frame, validates its length, prepends a header word, and streams the framed result to the DMA master port.
- Malformed frames are discarded atomically, so the DMA never sees partial CSI.

Parameters:
- FRAME_LEN, 64: data words per valid CSI frame (one per FFT bin).
- MAGIC, 16'hC510: constant placed in header bits [31:16].
- DROP_W, 16: width of the saturating dropped-frame counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- csi_axis_tvalid  input  1  CSI word valid
- csi_axis_tlast  input  1  last CSI word of frame
- csi_axis_tdata  input  32  CSI word {re[15:0], im[15:0]}
- csi_axis_tready  output  1  framer can accept a CSI word
- m_axis_tvalid  output  1  framed word valid
- m_axis_tlast  output  1  last word of framed packet
- m_axis_tdata  output  32  header or CSI word
- m_axis_tready  input  1  DMA accepts word
- frames_dropped_out  output  DROP_W  count of discarded frames, saturating
- busy_out  output  1  high in any state other than FILL with count 0

Behaviour:
- Reset state: FILL, write count 0, seq 0, frames_dropped_out 0.
  - All outputs low after reset, except csi_axis_tready, which is 1.
- Storage: FRAME_LEN x 32 buffer (inferred RAM, 1-cycle read latency). Single buffer, no ping-pong.
- A word transfers on any port only when tvalid && tready.
- FILL:
  - csi_axis_tready=1. Each transfer writes buf[count] and increments count.
  - Transfer with tlast and count==FRAME_LEN-1 -> frame complete -> HDR.
  - Transfer with tlast and count<FRAME_LEN-1 -> short frame: drop counter +1, count<=0, stay in FILL.
  - Transfer without tlast and count==FRAME_LEN-1 -> long frame -> DISCARD.
- DISCARD:
  - csi_axis_tready=1; words are consumed and not stored.
  - On the transfer carrying tlast: drop counter +1, count<=0 -> FILL.
- HDR:
  - csi_axis_tready=0 (upstream backpressure).
  - m_axis_tvalid=1, m_axis_tdata={MAGIC, seq[15:0]}, m_axis_tlast=0.
  - On handshake -> DATA.
- DATA:
  - Emits buf[0..FRAME_LEN-1] in order; m_axis_tlast=1 on word FRAME_LEN-1.
  - Read prefetch must hide the RAM latency: no bubble between header and word 0, or between successive words, while m_axis_tready stays high.
  - tdata and tlast must be held stable while tvalid && !tready.
  - After the tlast handshake: seq+1 (wraps 0xFFFF->0), count<=0 -> FILL.
- Latency:
  - First m_axis_tvalid of a frame is asserted no later than 2 cycles after the input tlast handshake.
  - Full packet is FRAME_LEN+1 beats minimum.
- Drop counter: saturates at 2^DROP_W-1 and never wraps. seq does not advance on a drop.
- m_axis_tvalid never drops before its handshake completes.
- A reset asserted mid-fill or mid-drain returns to the reset state on the next edge.
  - Any partial output packet is abandoned; m_axis_tvalid is low the cycle after reset.
- Simultaneous events: none possible, because input and output are never active in the same state.

Optional Feature:
- Macro: CSI_FRAMER_TIMESTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter (reset 0, wraps) is captured on the first accepted word of each frame in FILL.
  - A state TS between HDR and DATA emits the captured value as a second header word.
  - Packet length becomes FRAME_LEN+2.
  - Dropped frames discard their timestamp.
- Undefined: no counter, no TS state; packet length is FRAME_LEN+1.

Test Plan:
- Reset, then one 64-word frame with data=k (k=0..63), tlast on k=63, m_axis_tready=1 -> 65 beats: 0xC5100000, then 0..63, tlast only on the 65th beat. frames_dropped_out=0.
- Two back-to-back valid frames -> headers 0xC5100000 then 0xC5100001. csi_axis_tready is low from the first frame's tlast until the first frame's output tlast handshake.
- 10-word frame with tlast on word 9, then a valid 64-word frame -> frames_dropped_out=1; only the valid frame is output, with header seq 0.
- 70-word frame with tlast on word 69 -> all 70 words accepted, no output, frames_dropped_out=1; the following valid frame is output intact.
- Valid frame with m_axis_tready toggling pseudo-randomly at 50% -> output sequence identical to the first test; tdata is never changed while stalled.
- Reset asserted after 30 output beats -> m_axis_tvalid=0 next cycle; the next frame's header carries seq 0.
  - With CSI_FRAMER_TIMESTAMP_EN defined, the first test yields 66 beats, and beat 2 equals the cycle count at the first input handshake.
